// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the UART RX/TX buffers and their register file.
// The default address width, depth and almost-full threshold live here so that
// fifo_ctrl instances and the register file beside them agree on sizing.
// Ports: none (package).
package fifo_ctrl_pkg;

  localparam int FIFO_W        = 3;
  localparam int FIFO_DEPTH    = 2 ** FIFO_W;
  localparam int FIFO_AF_LEVEL = 6;

  // Accepted-operation code, formed as {push_ok, pop_ok}.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between the UART datapath and fifo_ctrl.
// master : UART datapath side (issues wr/rd, observes addresses and flags).
// slave  : fifo_ctrl side.
// Signals: wr, rd (requests); wr_en, w_addr, r_addr (register file control);
//          empty, full, almost_full, count (status); ovf, udf (error pulses).
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int W = FIFO_W
) ();

  logic         wr;
  logic         rd;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic [W:0]   count;
  logic         ovf;
  logic         udf;

  modport master (
    output wr, rd,
    input  wr_en, w_addr, r_addr, empty, full, almost_full, count, ovf, udf
  );

  modport slave (
    input  wr, rd,
    output wr_en, w_addr, r_addr, empty, full, almost_full, count, ovf, udf
  );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a 2**W-entry register-file FIFO.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fifo_ctrl_if slave: wr/rd requests in; wr_en (combinational),
//          w_addr/r_addr, empty, full, almost_full, count, ovf, udf out
//          (all registered).
// The register file reads r_data combinationally at r_addr, so the head entry
// is visible before rd is asserted and a pop completes in the same cycle.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int W        = FIFO_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic      clk,
  input  logic      rst,
  fifo_ctrl_if.slave bus
);

  localparam logic [W-1:0] PTR_ONE = W'(1);
  localparam logic [W:0]   CNT_ONE = (W + 1)'(1);
  localparam logic [W:0]   AF_THR  = (W + 1)'(AF_LEVEL);

  logic [W-1:0] w_ptr, w_ptr_nxt;
  logic [W-1:0] r_ptr, r_ptr_nxt;
  logic [W:0]   count_q, count_nxt;
  logic         empty_q, empty_nxt;
  logic         full_q, full_nxt;
  logic         af_q;
  logic         ovf_q;
  logic         udf_q;
  logic         push_ok;
  logic         pop_ok;
  fifo_op_e     op;

  // A push into a full FIFO is still accepted when a pop frees the same slot
  // in this cycle; the register file write lands at the edge, after the read.
  assign push_ok = bus.wr & (~full_q | bus.rd);
  assign pop_ok  = bus.rd & ~empty_q;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  always_comb begin
    w_ptr_nxt = w_ptr;
    r_ptr_nxt = r_ptr;
    count_nxt = count_q;
    empty_nxt = empty_q;
    full_nxt  = full_q;
    case (op)
      OP_PUSH: begin
        w_ptr_nxt = w_ptr + PTR_ONE;
        count_nxt = count_q + CNT_ONE;
        empty_nxt = 1'b0;
        full_nxt  = ((w_ptr + PTR_ONE) == r_ptr);
      end
      OP_POP: begin
        r_ptr_nxt = r_ptr + PTR_ONE;
        count_nxt = count_q - CNT_ONE;
        full_nxt  = 1'b0;
        empty_nxt = ((r_ptr + PTR_ONE) == w_ptr);
      end
      OP_BOTH: begin
        w_ptr_nxt = w_ptr + PTR_ONE;
        r_ptr_nxt = r_ptr + PTR_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr   <= w_ptr_nxt;
      r_ptr   <= r_ptr_nxt;
      count_q <= count_nxt;
      empty_q <= empty_nxt;
      full_q  <= full_nxt;
      af_q    <= (count_nxt >= AF_THR);
      ovf_q   <= bus.wr & full_q & ~bus.rd;
      udf_q   <= bus.rd & empty_q;
    end
  end

  assign bus.wr_en       = push_ok;
  assign bus.w_addr      = w_ptr;
  assign bus.r_addr      = r_ptr;
  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural register file and a
// queue-based reference model of the buffer contents.
// Ports: none (top-level bench).
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int W     = FIFO_W;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int AF    = FIFO_AF_LEVEL;

  typedef logic [W-1:0] ptr_t;
  typedef logic [W:0]   cnt_t;

  logic clk;
  logic rst;
  logic [7:0] wdata;
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] r_data;

  fifo_ctrl_if #(.W(W)) bus ();

  fifo_ctrl #(.W(W), .AF_LEVEL(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file stand-in: synchronous write, combinational read.
  always @(posedge clk) if (bus.wr_en) mem[bus.w_addr] <= wdata;
  assign r_data = mem[bus.r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue plus totals of accepted operations.
  logic [7:0] q [$];
  int push_total;
  int pop_total;

  logic       obs_wen;
  logic [7:0] obs_rdata;
  logic       exp_push;
  logic       exp_pop;
  logic [7:0] exp_rdata;
  logic       exp_ovf;
  logic       exp_udf;

  task automatic apply_reset();
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    wdata  = 8'h00;
    rst    = 1'b1;
    q.delete();
    push_total = 0;
    pop_total  = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock of stimulus; captures combinational outputs before the edge and
  // advances the model at the edge. Returns 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit m_full, m_empty;
    bus.wr = w;
    bus.rd = r;
    wdata  = d;
    #1;
    obs_wen   = bus.wr_en;
    obs_rdata = r_data;
    m_full    = (q.size() == DEPTH);
    m_empty   = (q.size() == 0);
    exp_push  = w && (!m_full || r);
    exp_pop   = r && !m_empty;
    exp_rdata = m_empty ? 8'h00 : q[0];
    exp_ovf   = w && m_full && !r;
    exp_udf   = r && m_empty;
    @(posedge clk);
    if (exp_pop) begin
      void'(q.pop_front());
      pop_total++;
    end
    if (exp_push) begin
      q.push_back(d);
      push_total++;
    end
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.count !== cnt_t'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", bus.almost_full); end
    checks++; if (bus.w_addr !== ptr_t'(0) || bus.r_addr !== ptr_t'(0)) begin errors++; $display("FAIL reset_addr: got w=%0d r=%0d expected 0 0", bus.w_addr, bus.r_addr); end
    checks++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin errors++; $display("FAIL reset_err: got ovf=%b udf=%b expected 0 0", bus.ovf, bus.udf); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'h10 + 8'(i));
      checks++; if (obs_wen !== 1'b1) begin errors++; $display("FAIL fill_wen[%0d]: got %b expected 1", i, obs_wen); end
      checks++; if (bus.count !== cnt_t'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i + 1); end
      checks++; if (bus.almost_full !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, bus.almost_full, (i + 1 >= AF)); end
      checks++; if (bus.full !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.full, (i == DEPTH - 1)); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, bus.empty); end
    end
    checks++; if (bus.w_addr !== ptr_t'(0)) begin errors++; $display("FAIL fill_wrap: got w_addr=%0d expected 0", bus.w_addr); end
    step(1'b1, 1'b0, 8'hEE);
    checks++; if (obs_wen !== 1'b0) begin errors++; $display("FAIL ovf_wen: got %b expected 0", obs_wen); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", bus.ovf); end
    checks++; if (bus.count !== cnt_t'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", bus.count, DEPTH); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b expected 0", bus.ovf); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (obs_rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, obs_rdata, 8'h10 + 8'(i)); end
      checks++; if (bus.count !== cnt_t'(DEPTH - 1 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, bus.count, DEPTH - 1 - i); end
      checks++; if (bus.empty !== (i == DEPTH - 1)) begin errors++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, bus.empty, (i == DEPTH - 1)); end
    end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (bus.udf !== 1'b1) begin errors++; $display("FAIL udf_pulse: got %b expected 1", bus.udf); end
    checks++; if (bus.r_addr !== ptr_t'(0)) begin errors++; $display("FAIL udf_raddr: got %0d expected 0", bus.r_addr); end
    step(1'b0, 1'b0, 8'h00);
    checks++; if (bus.udf !== 1'b0) begin errors++; $display("FAIL udf_one_cycle: got %b expected 0", bus.udf); end
  endtask

  task automatic test_simul_full();
    logic [7:0] exp_seq [DEPTH];
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
    step(1'b1, 1'b1, 8'h55);
    checks++; if (obs_rdata !== 8'h10) begin errors++; $display("FAIL sf_rdata: got %h expected 10", obs_rdata); end
    checks++; if (obs_wen !== 1'b1) begin errors++; $display("FAIL sf_wen: got %b expected 1", obs_wen); end
    checks++; if (bus.full !== 1'b1 || bus.count !== cnt_t'(DEPTH)) begin errors++; $display("FAIL sf_full: got full=%b count=%0d expected 1 %0d", bus.full, bus.count, DEPTH); end
    checks++; if (bus.w_addr !== ptr_t'(1) || bus.r_addr !== ptr_t'(1)) begin errors++; $display("FAIL sf_ptrs: got w=%0d r=%0d expected 1 1", bus.w_addr, bus.r_addr); end
    checks++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin errors++; $display("FAIL sf_err: got ovf=%b udf=%b expected 0 0", bus.ovf, bus.udf); end
    for (int i = 0; i < DEPTH - 1; i++) exp_seq[i] = 8'h11 + 8'(i);
    exp_seq[DEPTH - 1] = 8'h55;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (obs_rdata !== exp_seq[i]) begin errors++; $display("FAIL sf_drain[%0d]: got %h expected %h", i, obs_rdata, exp_seq[i]); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sf_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_simul_empty();
    step(1'b1, 1'b1, 8'hAA);
    checks++; if (obs_wen !== 1'b1) begin errors++; $display("FAIL se_wen: got %b expected 1", obs_wen); end
    checks++; if (bus.udf !== 1'b1) begin errors++; $display("FAIL se_udf: got %b expected 1", bus.udf); end
    checks++; if (bus.count !== cnt_t'(1) || bus.empty !== 1'b0) begin errors++; $display("FAIL se_state: got count=%0d empty=%b expected 1 0", bus.count, bus.empty); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (obs_rdata !== 8'hAA) begin errors++; $display("FAIL se_pop: got %h expected aa", obs_rdata); end
    checks++; if (bus.empty !== 1'b1 || bus.udf !== 1'b0) begin errors++; $display("FAIL se_after: got empty=%b udf=%b expected 1 0", bus.empty, bus.udf); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'h77);
    checks++; if (bus.ovf !== 1'b1 || bus.full !== 1'b1 || bus.w_addr !== ptr_t'(1)) begin errors++; $display("FAIL mid_pre: got ovf=%b full=%b w=%0d expected 1 1 1", bus.ovf, bus.full, bus.w_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.count !== cnt_t'(0) || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin errors++; $display("FAIL mid_flags: got count=%0d empty=%b full=%b af=%b expected 0 1 0 0", bus.count, bus.empty, bus.full, bus.almost_full); end
    checks++; if (bus.w_addr !== ptr_t'(0) || bus.r_addr !== ptr_t'(0) || bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin errors++; $display("FAIL mid_ptrs: got w=%0d r=%0d ovf=%b udf=%b expected 0 0 0 0", bus.w_addr, bus.r_addr, bus.ovf, bus.udf); end
    bus.wr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    push_total = 0;
    pop_total  = 0;
  endtask

  task automatic test_soak();
    bit   w, r, wr_phase;
    ptr_t prev_w;
    int   wraps;
    int   diff;
    wraps = 0;
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      wr_phase = ((i / 100) % 2) == 0;
      w = ($urandom_range(99) < (wr_phase ? 80 : 60));
      r = ($urandom_range(99) < (wr_phase ? 60 : 80));
      prev_w = bus.w_addr;
      step(w, r, 8'($urandom));
      if (prev_w == ptr_t'(DEPTH - 1) && bus.w_addr == ptr_t'(0)) wraps++;
      checks++; if (obs_wen !== exp_push) begin errors++; $display("FAIL soak_wen[%0d]: got %b expected %b", i, obs_wen, exp_push); end
      if (exp_pop) begin
        checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL soak_data[%0d]: got %h expected %h", i, obs_rdata, exp_rdata); end
      end
      checks++; if (bus.count !== cnt_t'(q.size())) begin errors++; $display("FAIL soak_count[%0d]: got %0d expected %0d", i, bus.count, q.size()); end
      checks++; if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH)) begin errors++; $display("FAIL soak_flags[%0d]: got empty=%b full=%b expected %b %b", i, bus.empty, bus.full, (q.size() == 0), (q.size() == DEPTH)); end
      checks++; if (bus.almost_full !== (q.size() >= AF)) begin errors++; $display("FAIL soak_af[%0d]: got %b expected %b", i, bus.almost_full, (q.size() >= AF)); end
      checks++; if (bus.ovf !== exp_ovf || bus.udf !== exp_udf) begin errors++; $display("FAIL soak_err[%0d]: got ovf=%b udf=%b expected %b %b", i, bus.ovf, bus.udf, exp_ovf, exp_udf); end
      checks++; if (bus.w_addr !== ptr_t'(push_total % DEPTH) || bus.r_addr !== ptr_t'(pop_total % DEPTH)) begin errors++; $display("FAIL soak_ptrs[%0d]: got w=%0d r=%0d expected %0d %0d", i, bus.w_addr, bus.r_addr, push_total % DEPTH, pop_total % DEPTH); end
      diff = (int'(bus.w_addr) - int'(bus.r_addr) + DEPTH) % DEPTH;
      checks++; if (int'(bus.count) != (bus.full ? DEPTH : diff)) begin errors++; $display("FAIL soak_invariant[%0d]: got count=%0d expected %0d", i, bus.count, (bus.full ? DEPTH : diff)); end
    end
    checks++; if (wraps < 50) begin errors++; $display("FAIL soak_wraps: got %0d expected at least 50", wraps); end
  endtask

  initial begin
    rst    = 1'b1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    wdata  = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_simul_full();
    test_simul_empty();
    test_reset_mid();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
